// File: rtl/dump_pkg.sv
// Shared definitions for the data memory dump engine and the debug unit.
package dump_pkg;

  localparam int DUMP_ADDR_W = 11;
  localparam int DUMP_DATA_W = 16;
  localparam int BYTE_W      = 8;

  // 3-bit state encoding, reused by the debug unit to decode dump progress
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_SEND_HI = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/data_memory_dump_if.sv
// Memory read bus plus byte stream towards the debug UART transmitter.
interface data_memory_dump_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] addr_data;
  logic              write;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // Dump engine side
  modport master (
    output addr_data, write, tx_data, tx_valid,
    input  out_data, tx_ready
  );

  // Memory / transmitter side
  modport slave (
    input  addr_data, write, tx_data, tx_valid,
    output out_data, tx_ready
  );

endinterface

// File: rtl/data_memory_dump_word_to_byte_tx.sv
// Holds one fetched memory word and hands it out low byte first, then high
// byte, over a valid/ready handshake.
module word_to_byte_tx
  import dump_pkg::*;
#(
  parameter int DATA_W = DUMP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_ready,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ack
);

  logic [DATA_W-1:0] r_word;
  logic              r_hi;
  logic              r_valid;

  // Word register is pure data: loaded once per fetch, never reset
  always_ff @(posedge clk) begin
    if (i_load) r_word <= i_word;
  end

  // Byte selector and valid: raise valid on load, step lo -> hi -> idle on each accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_hi    <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_hi    <= 1'b0;
    end else if (r_valid && i_ready) begin
      if (r_hi) r_valid <= 1'b0;
      r_hi <= ~r_hi;
    end
  end

  assign o_valid = r_valid;
  assign o_ack   = r_valid & i_ready;
  // Gate the byte with valid so the bus reads 0 when idle or after reset
  assign o_data  = !r_valid ? '0 :
                   (r_hi ? r_word[DATA_W-1 -: BYTE_W] : r_word[BYTE_W-1:0]);

endmodule

// File: rtl/data_memory_dump.sv
// Walks an inclusive, wrapping address range of data_memory and streams each
// word out as two bytes. Owns the memory address while busy; never writes.
module data_memory_dump
  import dump_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = DUMP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  data_memory_dump_if.master bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic              w_load;
  logic              w_ack;
  logic              w_valid;
  logic [7:0]        w_byte;

  // State register plus address counter and remaining-word count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start) begin
        r_addr      <= first_addr;
        // Modular difference makes last < first dump through the top and wrap
        r_remaining <= last_addr - first_addr;
      end else if (r_state == ST_SEND_HI && w_ack && r_remaining != '0) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  // Next-state and word-load strobe
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_READ;
      ST_READ:    w_next = ST_LATCH;
      ST_LATCH: begin
        // Synchronous memory: data addressed in READ is on out_data now
        w_load = 1'b1;
        w_next = ST_SEND_LO;
      end
      ST_SEND_LO: if (w_ack) w_next = ST_SEND_HI;
      ST_SEND_HI: if (w_ack) w_next = (r_remaining == '0) ? ST_DONE : ST_READ;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  word_to_byte_tx #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_word  (bus.out_data),
    .i_ready (bus.tx_ready),
    .o_data  (w_byte),
    .o_valid (w_valid),
    .o_ack   (w_ack)
  );

  assign bus.addr_data = r_addr;
  assign bus.write     = 1'b0;
  assign bus.tx_data   = w_byte;
  assign bus.tx_valid  = w_valid;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);

endmodule

// File: doc/data_memory_dump.md
# data_memory_dump

Read-side initiator for `data_memory`: on command, walks an address range of the data memory, fetches each 16-bit word, and streams it out as two bytes over a valid/ready byte interface feeding the debug UART transmitter. It owns the memory address and write-enable while busy, so the CPU datapath must be halted or muxed away. It is the reader counterpart to the CPU store path that fills `data_memory`.

## Interface

- `ADDR_W`, 11, data memory address width.
- `DATA_W`, 16, data memory word width; must equal 2×8.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse; begins a dump when idle.
- `first_addr`  in  ADDR_W  first word address, sampled on accepted `start`.
- `last_addr`  in  ADDR_W  last word address (inclusive), sampled on accepted `start`.
- `addr_data`  out  ADDR_W  address to `data_memory`.
- `write`  out  1  write enable to `data_memory`; constant 0.
- `out_data`  in  DATA_W  read data from `data_memory`.
- `tx_data`  out  8  byte to transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts byte.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse after last byte accepted.

## Operation

- FSM states: IDLE, READ, LATCH, SEND_LO, SEND_HI, DONE.
- IDLE: `start`=1 → capture `first_addr` into addr counter, compute `remaining` = (`last_addr` − `first_addr`) mod 2^ADDR_W; → READ.
- READ: drive `addr_data` = counter; → LATCH.
- LATCH: `out_data` is valid (memory has one-cycle synchronous read); capture into word register; → SEND_LO.
- SEND_LO: `tx_data` = word[7:0], `tx_valid`=1; hold until `tx_ready`; → SEND_HI.
- SEND_HI: `tx_data` = word[15:8], `tx_valid`=1; on `tx_ready`: if `remaining`==0 → DONE, else counter+1, `remaining`−1, → READ.
- DONE: `done`=1 for one cycle; → IDLE.
- Address counter wraps modulo 2^ADDR_W: `last_addr` < `first_addr` dumps through 2047→0. `first_addr`==`last_addr` dumps exactly one word.
- `start` outside IDLE is ignored; the range is not re-sampled.
- `tx_data` stays stable while `tx_valid`=1 and `tx_ready`=0.
- `busy` = 1 in every state except IDLE.
- `write` tied 0; this block never modifies memory.

## Timing

- Reset values: state IDLE, `addr_data`=0, `write`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0.
- `start` sampled at edge E0 → READ during cycle 1, LATCH cycle 2, `tx_valid` first high cycle 3.
- With `tx_ready` held 1, each word costs 4 cycles (READ, LATCH, SEND_LO, SEND_HI); N words take 4N cycles, and `done` is high in cycle 4N+1.
- `addr_data` is registered, holds its value outside READ, and changes only on entry to READ.
- `reset` mid-dump: next cycle is IDLE with all outputs at reset values. A byte in flight is dropped, and the transmitter must tolerate `tx_valid` falling without a handshake.
- `tx_ready` while `tx_valid`=0 has no effect.

## Structure

- Shared package `dump_pkg`: ADDR_W/DATA_W defaults and the state encoding localparams (3-bit). The debug unit reuses these.
- One natural sub-module: `word_to_byte_tx`. It holds the 16-bit word register and the lo/hi byte selector, and runs the valid/ready handshake. The top FSM handles address sequencing and count.

## Test plan

- Reset, then memory preloaded with addr 5 = 0x1234, `first_addr`=`last_addr`=5, `tx_ready`=1 → bytes 0x34, 0x12; `done` in cycle 5; `busy` high cycles 1–4.
- Range 0..3 holding 0x0001, 0x0002, 0x0003, 0xABCD, `tx_ready`=1 → 8 bytes 01 00 02 00 03 00 CD AB; `done` at cycle 17.
- Wrap: `first_addr`=2046, `last_addr`=1 → addresses 2046, 2047, 0, 1 in order; 8 bytes.
- Backpressure: `tx_ready` low for 5 cycles during SEND_HI → `tx_data`/`tx_valid` stable throughout; byte order unchanged.
- `start` pulsed while busy → ignored; `reset` asserted in SEND_LO → next cycle `busy`=0, `tx_valid`=0, `addr_data`=0, and a fresh `start` dumps correctly.
